// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation engine: encrypted = plain^expo mod modulo.
// Right-to-left square-and-multiply built on two bit-serial Blakley multipliers.
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             run,
  input  logic [WIDTH-1:0] plain,
  input  logic [WIDTH-1:0] expo,
  input  logic [WIDTH-1:0] modulo,
  output logic [WIDTH-1:0] encrypted,
  output logic             eoc,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   pr_q, pr_d;
  logic [WIDTH:0]   ps_q, ps_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic [WIDTH-1:0] enc_q, enc_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   pr_next, ps_next;

  // One interleaved step: P = 2P + a_bit*b, kept below m. P < m on entry, so
  // each partial result stays under 2m and a single conditional subtract suffices.
  function automatic logic [WIDTH:0] blakley_step(input logic [WIDTH:0] p,
                                                  input logic [WIDTH:0] b,
                                                  input logic [WIDTH:0] m,
                                                  input logic           a_bit);
    logic [WIDTH:0] t;
    t = p << 1;
    if (t >= m) t = t - m;
    if (a_bit) begin
      t = t + b;
      if (t >= m) t = t - m;
    end
    return t;
  endfunction

  always_comb begin
    pr_next = blakley_step(pr_q, {1'b0, r_q}, {1'b0, m_q}, b_q[i_q]);
    ps_next = blakley_step(ps_q, {1'b0, b_q}, {1'b0, m_q}, b_q[i_q]);
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    e_d     = e_q;
    m_d     = m_q;
    r_d     = r_q;
    b_d     = b_q;
    pr_d    = pr_q;
    ps_d    = ps_q;
    i_d     = i_q;
    j_d     = j_q;
    enc_d   = enc_q;
    err_d   = err_q;

    if (en) begin
      case (state_q)
        S_IDLE: begin
          err_d = 1'b0;
          if (run) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (!run) begin
            state_d = S_IDLE;
          end else begin
            e_d = expo;
            m_d = modulo;
            if (modulo < WIDTH'(2) || plain >= modulo) begin
              enc_d   = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              r_d     = WIDTH'(1);
              b_d     = plain;
              pr_d    = '0;
              ps_d    = '0;
              i_d     = LAST;
              j_d     = '0;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!run) begin
            state_d = S_IDLE;
          end else if (i_q == '0) begin
            // Exponent bit finished: square base, conditionally multiply result.
            b_d  = ps_next[WIDTH-1:0];
            if (e_q[j_q]) r_d = pr_next[WIDTH-1:0];
            pr_d = '0;
            ps_d = '0;
            i_d  = LAST;
            j_d  = j_q + CW'(1);
            if (j_q == LAST) begin
              enc_d   = e_q[j_q] ? pr_next[WIDTH-1:0] : r_q;
              state_d = S_DONE;
            end
          end else begin
            pr_d = pr_next;
            ps_d = ps_next;
            i_d  = i_q - CW'(1);
          end
        end
        default: begin
          if (!run) state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      e_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      pr_q    <= '0;
      ps_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      enc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r_q     <= r_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      ps_q    <= ps_d;
      i_q     <= i_d;
      j_q     <= j_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
    end
  end

  assign encrypted = enc_q;
  assign err       = err_q;
  assign eoc       = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_CALC);

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed bench for rsa_modexp_unit (WIDTH=8) with hand-computed results.
module tb_rsa_modexp_unit;

  logic       clk = 1'b0;
  logic       rst, en, run;
  logic [7:0] plain, expo, modulo;
  logic [7:0] encrypted;
  logic       eoc, err, busy;
  int         checks = 0;
  int         failures = 0;

  rsa_modexp_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .run(run),
    .plain(plain), .expo(expo), .modulo(modulo),
    .encrypted(encrypted), .eoc(eoc), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    plain  = p;
    expo   = e;
    modulo = m;
    run    = 1'b1;
  endtask

  // Counts edges from the first run=1 edge until eoc is seen; -1 on timeout.
  // en is dropped after edge off_at for off_len edges (off_len=0: no stall).
  task automatic wait_eoc(input int limit, input int off_at, input int off_len,
                          output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (edges < limit) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
      if (off_len > 0 && edges == off_at) en = 1'b0;
      if (off_len > 0 && edges == off_at + off_len) en = 1'b1;
      if (eoc) break;
    end
    if (!eoc) edges = -1;
  endtask

  task automatic release_run();
    run = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; run = 1'b0;
    plain = '0; expo = '0; modulo = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (encrypted !== 8'd0) begin failures++; $display("FAIL reset_encrypted got=%0d exp=0", encrypted); end
    checks++; if (eoc !== 1'b0) begin failures++; $display("FAIL reset_eoc got=%b exp=0", eoc); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int edges, bc;
    start_op(8'd5, 8'd3, 8'd33);
    wait_eoc(200, 0, 0, edges, bc);
    checks++; if (edges !== 66) begin failures++; $display("FAIL basic_latency got=%0d exp=66", edges); end
    checks++; if (bc !== 65) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=65", bc); end
    checks++; if (encrypted !== 8'd26) begin failures++; $display("FAIL basic_result got=%0d exp=26", encrypted); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
    run = 1'b0;
    tick();
    checks++; if (eoc !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle eoc=%b busy=%b exp=0,0", eoc, busy); end
    checks++; if (encrypted !== 8'd26) begin failures++; $display("FAIL basic_retain got=%0d exp=26", encrypted); end
    tick();
  endtask

  task automatic test_vectors();
    logic [7:0] vp [3] = '{8'd100, 8'd254, 8'd7};
    logic [7:0] ve [3] = '{8'd7,   8'd255, 8'd0};
    logic [7:0] vm [3] = '{8'd143, 8'd255, 8'd33};
    logic [7:0] vr [3] = '{8'd100, 8'd254, 8'd1};
    int edges, bc;
    for (int k = 0; k < 3; k++) begin
      start_op(vp[k], ve[k], vm[k]);
      wait_eoc(200, 0, 0, edges, bc);
      checks++; if (edges !== 66) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=66", k, edges); end
      checks++; if (encrypted !== vr[k]) begin failures++; $display("FAIL vec%0d_result got=%0d exp=%0d", k, encrypted, vr[k]); end
      release_run();
    end
  endtask

  task automatic test_error();
    logic [7:0] vp [2] = '{8'd5, 8'd40};
    logic [7:0] vm [2] = '{8'd1, 8'd33};
    int edges, bc;
    for (int k = 0; k < 2; k++) begin
      start_op(vp[k], 8'd3, vm[k]);
      wait_eoc(20, 0, 0, edges, bc);
      checks++; if (edges !== 2) begin failures++; $display("FAIL err%0d_latency got=%0d exp=2", k, edges); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err%0d_flag got=%b exp=1", k, err); end
      checks++; if (encrypted !== 8'd0) begin failures++; $display("FAIL err%0d_result got=%0d exp=0", k, encrypted); end
      release_run();
    end
  endtask

  task automatic test_abort();
    int  edges, bc;
    logic saw_eoc;
    start_op(8'd5, 8'd3, 8'd33);
    wait_eoc(200, 0, 0, edges, bc);
    checks++; if (encrypted !== 8'd26) begin failures++; $display("FAIL abort_pre got=%0d exp=26", encrypted); end
    release_run();
    start_op(8'd2, 8'd5, 8'd221);
    repeat (22) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_calc got=%b exp=1", busy); end
    run = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || eoc !== 1'b0) begin failures++; $display("FAIL abort_idle busy=%b eoc=%b exp=0,0", busy, eoc); end
    saw_eoc = 1'b0;
    repeat (5) begin
      tick();
      if (eoc) saw_eoc = 1'b1;
    end
    checks++; if (saw_eoc !== 1'b0) begin failures++; $display("FAIL abort_no_eoc got=%b exp=0", saw_eoc); end
    checks++; if (encrypted !== 8'd26) begin failures++; $display("FAIL abort_retain got=%0d exp=26", encrypted); end
    start_op(8'd2, 8'd5, 8'd221);
    wait_eoc(200, 0, 0, edges, bc);
    checks++; if (edges !== 66) begin failures++; $display("FAIL restart_latency got=%0d exp=66", edges); end
    checks++; if (encrypted !== 8'd32) begin failures++; $display("FAIL restart_result got=%0d exp=32", encrypted); end
    release_run();
  endtask

  task automatic test_en_stall();
    int edges, bc;
    start_op(8'd5, 8'd3, 8'd33);
    wait_eoc(200, 30, 10, edges, bc);
    checks++; if (edges !== 76) begin failures++; $display("FAIL stall_latency got=%0d exp=76", edges); end
    checks++; if (encrypted !== 8'd26) begin failures++; $display("FAIL stall_result got=%0d exp=26", encrypted); end
    release_run();
  endtask

  task automatic test_rst_mid();
    start_op(8'd100, 8'd7, 8'd143);
    repeat (20) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (encrypted !== 8'd0) begin failures++; $display("FAIL rstmid_encrypted got=%0d exp=0", encrypted); end
    checks++; if (eoc !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_flags eoc=%b err=%b busy=%b exp=0,0,0", eoc, err, busy);
    end
    rst = 1'b0;
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_error();
    test_abort();
    test_en_stall();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
